// File: rtl/ram_arb_pkg.sv
// Shared types for the two-client RAM arbiter: FSM states, client id and read-return tag.
package ram_arb_pkg;

  typedef enum logic [0:0] {INIT, RUN} state_e;

  typedef logic client_id_t;

  localparam client_id_t CLIENT0 = 1'b0;
  localparam client_id_t CLIENT1 = 1'b1;

  typedef struct packed {
    logic       valid;
    client_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Client command/response and RAM pin bundle between the two clients, the arbiter and the RAM.
interface ram_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 20,
  parameter int unsigned ADDR_WIDTH = 10
);

  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  rvalid0;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata0;
  logic [DATA_WIDTH-1:0] rdata1;
  logic                  busy;
  logic                  ram_write;
  logic                  ram_load;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0] ram_data;
  logic [DATA_WIDTH-1:0] ram_q;

  // Arbiter side.
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_q,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy,
    output ram_write, ram_load, ram_address, ram_data
  );

  // Clients plus RAM side.
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_q,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy,
    input  ram_write, ram_load, ram_address, ram_data
  );

endinterface

// File: rtl/rr_arbiter_2.sv
// Combinational two-way round-robin picker; on a tie the client that did not win last goes first.
module rr_arbiter_2
  import ram_arb_pkg::*;
(
  input  logic [1:0] elig,
  input  client_id_t last,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    unique case (elig)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = (last == CLIENT1) ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-client round-robin sequencer for a single-port registered RAM.
// Define RAM_ARB_INIT_EN to clear the whole RAM after reset before serving clients.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 20,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input logic          clk,
  input logic          rst,
  ram_arbiter_if.slave bus
);

  logic [1:0]            elig;
  logic [1:0]            win;
  logic                  gnt0_q, gnt0_d;
  logic                  gnt1_q, gnt1_d;
  logic                  write_q, write_d;
  logic                  load_q, load_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  client_id_t            last_q, last_d;
  rd_tag_t               tag0_q, tag0_d;
  rd_tag_t               tag1_q;
  logic                  init_wr;
  logic [ADDR_WIDTH-1:0] init_addr;

`ifdef RAM_ARB_INIT_EN
  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   init_cnt_q, init_cnt_d;
  logic                  busy_q;
  logic                  init_last;

  assign init_last = (init_cnt_q == (ADDR_WIDTH+1)'(RAM_DEPTH - 1));

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_last) begin
        state_d = RUN;
      end
    end
  end

  // busy lags the state by one cycle so it drops only once the last clear write is on the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      busy_q     <= (state_q == INIT);
    end
  end

  assign init_wr   = (state_q == INIT);
  assign init_addr = init_cnt_q[ADDR_WIDTH-1:0];
  assign bus.busy  = busy_q;
`else
  assign init_wr   = 1'b0;
  assign init_addr = '0;
  assign bus.busy  = 1'b0;
`endif

  // A client in its grant cycle is not eligible, so a held request cannot win twice in a row.
  assign elig = {bus.req1 & ~gnt1_q, bus.req0 & ~gnt0_q} & {2{~init_wr}};

  rr_arbiter_2 u_rr (
    .elig (elig),
    .last (last_q),
    .win  (win)
  );

  always_comb begin
    gnt0_d  = win[0];
    gnt1_d  = win[1];
    write_d = 1'b0;
    load_d  = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    tag0_d  = '0;
    if (init_wr) begin
      write_d = 1'b1;
      addr_d  = init_addr;
      data_d  = '0;
    end else if (win[0]) begin
      write_d = bus.we0;
      load_d  = ~bus.we0;
      addr_d  = bus.addr0;
      data_d  = bus.wdata0;
      last_d  = CLIENT0;
      tag0_d  = '{valid: ~bus.we0, id: CLIENT0};
    end else if (win[1]) begin
      write_d = bus.we1;
      load_d  = ~bus.we1;
      addr_d  = bus.addr1;
      data_d  = bus.wdata1;
      last_d  = CLIENT1;
      tag0_d  = '{valid: ~bus.we1, id: CLIENT1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      write_q <= 1'b0;
      load_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= CLIENT1;
      tag0_q  <= '0;
      tag1_q  <= '0;
    end else begin
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      write_q <= write_d;
      load_q  <= load_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      tag0_q  <= tag0_d;
      tag1_q  <= tag0_q;
    end
  end

  assign bus.gnt0        = gnt0_q;
  assign bus.gnt1        = gnt1_q;
  assign bus.ram_write   = write_q;
  assign bus.ram_load    = load_q;
  assign bus.ram_address = addr_q;
  assign bus.ram_data    = data_q;
  assign bus.rvalid0     = tag1_q.valid & (tag1_q.id == CLIENT0);
  assign bus.rvalid1     = tag1_q.valid & (tag1_q.id == CLIENT1);
  assign bus.rdata0      = bus.ram_q;
  assign bus.rdata1      = bus.ram_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM and per-client read-data scoreboards.
// Covers the RAM_ARB_INIT_EN clear sequence when that macro is defined.
module tb_ram_arbiter;

`ifdef RAM_ARB_INIT_EN
  localparam logic BUSY_RST = 1'b1;
`else
  localparam logic BUSY_RST = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [19:0] mem    [1024];
  logic [19:0] shadow [1024];
  logic [19:0] q0 [$];
  logic [19:0] q1 [$];
  logic [19:0] mon_exp;

  ram_arbiter_if bus ();

  ram_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM with registered write and read.
  always @(posedge clk) begin
    if (bus.ram_write) mem[bus.ram_address] <= bus.ram_data;
    if (bus.ram_load) bus.ram_q <= mem[bus.ram_address];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rvalid0) begin
      if (q0.size() == 0) check("rvalid0_unexpected", 32'(bus.rvalid0), 32'd0);
      else begin
        mon_exp = q0.pop_front();
        check("sb_rdata0", 32'(bus.rdata0), 32'(mon_exp));
      end
    end
    if (bus.rvalid1) begin
      if (q1.size() == 0) check("rvalid1_unexpected", 32'(bus.rvalid1), 32'd0);
      else begin
        mon_exp = q1.pop_front();
        check("sb_rdata1", 32'(bus.rdata1), 32'(mon_exp));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int c, input logic r, input logic we, input logic [9:0] a,
                       input logic [19:0] d);
    if (c == 0) begin
      bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  task automatic push(input int c, input logic [19:0] d);
    if (c == 0) q0.push_back(d);
    else q1.push_back(d);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.busy && n < 1100) begin
      tick();
      n++;
    end
    check("busy_timeout", 32'(bus.busy), 32'd0);
  endtask

  // One command from one client: gnt and strobes one cycle later, rvalid one more cycle later.
  task automatic issue(input int c, input logic we, input logic [9:0] a, input logic [19:0] d,
                       input string tag);
    logic [19:0] exp;
    exp = shadow[a];
    drive(c, 1'b1, we, a, d);
    if (!we) push(c, exp);
    tick();
    check({tag, "_gnt"}, 32'((c == 0) ? bus.gnt0 : bus.gnt1), 32'd1);
    check({tag, "_other_gnt"}, 32'((c == 0) ? bus.gnt1 : bus.gnt0), 32'd0);
    check({tag, "_write"}, 32'(bus.ram_write), 32'(we));
    check({tag, "_load"}, 32'(bus.ram_load), 32'(!we));
    check({tag, "_addr"}, 32'(bus.ram_address), 32'(a));
    if (we) begin
      check({tag, "_data"}, 32'(bus.ram_data), 32'(d));
      shadow[a] = d;
    end
    drive(c, 1'b0, 1'b0, '0, '0);
    tick();
    if (!we) begin
      check({tag, "_rvalid"}, 32'((c == 0) ? bus.rvalid0 : bus.rvalid1), 32'd1);
      check({tag, "_rdata"}, 32'((c == 0) ? bus.rdata0 : bus.rdata1), 32'(exp));
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_gnt0"}, 32'(bus.gnt0), 32'd0);
    check({tag, "_gnt1"}, 32'(bus.gnt1), 32'd0);
    check({tag, "_rvalid0"}, 32'(bus.rvalid0), 32'd0);
    check({tag, "_rvalid1"}, 32'(bus.rvalid1), 32'd0);
    check({tag, "_ram_write"}, 32'(bus.ram_write), 32'd0);
    check({tag, "_ram_load"}, 32'(bus.ram_load), 32'd0);
    check({tag, "_ram_address"}, 32'(bus.ram_address), 32'd0);
    check({tag, "_ram_data"}, 32'(bus.ram_data), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'(BUSY_RST));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
`ifdef RAM_ARB_INIT_EN
      mem[i] = 20'hABCDE;
`else
      mem[i] = 20'h0;
`endif
      shadow[i] = 20'h0;
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);

    // Reset with no requests.
    rst = 1'b1;
    repeat (3) tick();
    check_reset_values("reset");
    rst = 1'b0;

`ifdef RAM_ARB_INIT_EN
    begin
      int cnt = 0;
      // A request held through the clear sequence is served first, and reads back 0.
      drive(0, 1'b1, 1'b0, 10'h155, '0);
      push(0, 20'h0);
      for (int n = 0; n < 1100; n++) begin
        tick();
        if (bus.busy) check("gnt_while_busy", 32'(bus.gnt0), 32'd0);
        if (bus.ram_write) begin
          check("init_addr", 32'(bus.ram_address), 32'(cnt));
          check("init_data", 32'(bus.ram_data), 32'd0);
          cnt++;
        end
        if (!bus.busy) break;
      end
      check("init_count", 32'(cnt), 32'd1024);
      check("first_gnt_after_busy", 32'(bus.gnt0), 32'd1);
      drive(0, 1'b0, 1'b0, '0, '0);
      tick();
      check("first_read_rvalid", 32'(bus.rvalid0), 32'd1);
      check("first_read_rdata", 32'(bus.rdata0), 32'd0);
    end
`endif
    tick();

    // Client 0 write then read back.
    issue(0, 1'b1, 10'h010, 20'h12345, "c0_wr");
    issue(0, 1'b0, 10'h010, 20'h0, "c0_rd");

    // Cross-client read-after-write at the top address.
    issue(1, 1'b1, 10'h3FF, 20'hFFFFF, "c1_wr_top");
    issue(0, 1'b0, 10'h3FF, 20'h0, "c0_rd_top");

    // Preload, leaving client 1 as last winner.
    issue(0, 1'b1, 10'h030, 20'h05555, "c0_wr_pre");
    issue(1, 1'b1, 10'h020, 20'h0AAAA, "c1_wr_pre");

    // Both clients read every cycle: grants alternate starting with client 0.
    drive(0, 1'b1, 1'b0, 10'h030, '0);
    drive(1, 1'b1, 1'b0, 10'h020, '0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("alt_gnt0", 32'(bus.gnt0), 32'((k % 2) == 0));
      check("alt_gnt1", 32'(bus.gnt1), 32'((k % 2) == 1));
      check("alt_load", 32'(bus.ram_load), 32'd1);
      check("alt_addr", 32'(bus.ram_address), ((k % 2) == 0) ? 32'h030 : 32'h020);
      if ((k % 2) == 0) push(0, shadow[10'h030]);
      else push(1, shadow[10'h020]);
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (3) tick();

    // Client 1 holds its request: served every second cycle only.
    drive(1, 1'b1, 1'b0, 10'h3FF, '0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("hold_gnt1", 32'(bus.gnt1), 32'((k % 2) == 0));
      check("hold_gnt0", 32'(bus.gnt0), 32'd0);
      if ((k % 2) == 0) push(1, shadow[10'h3FF]);
    end
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (3) tick();

    // Reset right after a read grant: the read must never return.
    drive(0, 1'b1, 1'b0, 10'h010, '0);
    tick();
    check("rst_rd_gnt0", 32'(bus.gnt0), 32'd1);
    drive(0, 1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    tick();
    check_reset_values("midrst");
    rst = 1'b0;
`ifdef RAM_ARB_INIT_EN
    for (int i = 0; i < 1024; i++) shadow[i] = 20'h0;
`endif
    wait_ready();
    repeat (2) tick();

    // Pointer restarts at client 1, so client 0 wins the first tie.
    drive(0, 1'b1, 1'b0, 10'h030, '0);
    drive(1, 1'b1, 1'b0, 10'h020, '0);
    push(0, shadow[10'h030]);
    push(1, shadow[10'h020]);
    tick();
    check("tie_gnt0", 32'(bus.gnt0), 32'd1);
    check("tie_gnt1_low", 32'(bus.gnt1), 32'd0);
    drive(0, 1'b0, 1'b0, '0, '0);
    tick();
    check("tie_gnt1", 32'(bus.gnt1), 32'd1);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (4) tick();

    check("sb_q0_drained", 32'(q0.size()), 32'd0);
    check("sb_q1_drained", 32'(q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester round-robin arbiter and sequencer for the shared single-port `ram` (20-bit data, 10-bit address, registered write and read on `posedge clk`). It accepts read and write commands from two independent clients, serialises them onto the RAM's `write`/`load`/`address`/`data` pins, and returns read data with a valid strobe. An optional post-reset sequencer clears the whole memory before any client gets access. It sits directly between the datapath clients and the `ram` instance.

## Interface
- `DATA_WIDTH`, 20: RAM word width.
- `ADDR_WIDTH`, 10: RAM address width.
- `RAM_DEPTH`, `1 << ADDR_WIDTH`: number of words; used by the init sequencer.

Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0`, `req1` in 1: client request. Held high, with its command stable, until the matching `gnt` is seen.
- `we0`, `we1` in 1: 1 = write, 0 = read.
- `addr0`, `addr1` in `ADDR_WIDTH`: command address.
- `wdata0`, `wdata1` in `DATA_WIDTH`: write data.
- `gnt0`, `gnt1` out 1: one-cycle pulse; the command is being driven to the RAM in this cycle.
- `rvalid0`, `rvalid1` out 1: one-cycle pulse; the matching `rdata` is valid.
- `rdata0`, `rdata1` out `DATA_WIDTH`: read data.
- `busy` out 1: init sequencer active; requests are not served.
- `ram_write`, `ram_load` out 1: RAM write and load strobes.
- `ram_address` out `ADDR_WIDTH`: RAM address.
- `ram_data` out `DATA_WIDTH`: RAM write data.
- `ram_q` in `DATA_WIDTH`: RAM registered read output.

## Operation
- FSM states:
  - INIT: present only with the macro; entered from reset.
  - RUN: normal service.
  - INIT → RUN after the write to address `RAM_DEPTH-1` is issued.
- Arbitration in RUN, each cycle:
  - Eligible = `reqX` high and `gntX` low in this cycle. A client is never re-granted in its own grant cycle.
  - One eligible client: it wins.
  - Both eligible: the client not granted most recently wins. The last-winner pointer resets to "client 1", so client 0 wins the first tie.
  - Pointer updates only on a grant.
- Issue: the winner's command is registered onto the RAM pins and `gntX` is registered high for the following cycle.
  - Write: `ram_write`=1, `ram_load`=0.
  - Read: `ram_load`=1, `ram_write`=0.
  - With no grant, `ram_write` and `ram_load` are 0, and `ram_address`/`ram_data` hold their last values.
- Read return:
  - A 2-entry tag pipeline of {valid, client id} tracks each read.
  - `rvalidX` is high in the cycle when `ram_q` holds the word.
  - `rdataX` = `ram_q`, combinational; it is defined only while `rvalidX` is high. Both `rdata` ports may show `ram_q` at any time.
- Writes produce no `rvalid`.
- Read-after-write to the same address from either client returns the new data, because the RAM executes commands in issue order.

## Timing
- Request sampled in cycle N:
  - `gnt` and RAM strobes high in N+1.
  - RAM executes on the edge ending N+1.
  - For reads, `rvalid` high in N+2.
- Throughput:
  - One RAM command per cycle when the two clients alternate.
  - A single client gets at most one command every 2 cycles.
- Reset values: `gnt0`/`gnt1`/`rvalid0`/`rvalid1`/`ram_write`/`ram_load` = 0, `ram_address` = 0, `ram_data` = 0, pointer = client 1.
  - `busy` resets to 1 with `RAM_ARB_INIT_EN`, otherwise to 0.
- Reset asserted mid-operation:
  - In-flight tags are cleared, so no `rvalid` is emitted for reads issued before reset.
  - The init sequence restarts from address 0.
- Simultaneous request on both clients while one client is in its grant cycle: the other client wins without consulting the pointer.

## Configuration
- `RAM_ARB_INIT_EN` defined:
  - After reset release, INIT issues one write of 0 per cycle to addresses 0 through `RAM_DEPTH-1`, in the first `RAM_DEPTH` cycles.
  - `busy` is high from reset until the cycle after the last init write.
  - Requests are held, not granted. The first grant can appear in the first cycle with `busy`=0.
- Not defined: there is no INIT state, `busy` is tied 0, and RUN is entered directly from reset.

## Structure
- Package `ram_arb_pkg`:
  - State enum {INIT, RUN}.
  - Client id type (1 bit).
  - Read-tag struct {valid, id}.
- Sub-module `rr_arbiter_2`: combinational two-way round-robin picker. Inputs are the eligible vector and the last-winner pointer; output is a one-hot winner.
- FSM, init counter (`ADDR_WIDTH`+1 bits), issue registers and tag pipeline live in `ram_arbiter`.

## Test plan
1. Reset, no requests: all outputs at reset values. With the macro, exactly 1024 writes of 0 to addresses 0..1023, then `busy` falls.
2. Client 0 writes 0x12345 to 0x010, then reads 0x010: `gnt0` one cycle after each request, and `rvalid0` with `rdata0`=0x12345 two cycles after the read request.
3. Both clients request reads every cycle: grants alternate 0,1,0,1 and each `rvalid` arrives on the correct client port with that client's data.
4. Client 1 holds `req1` continuously: grants every second cycle and never two consecutive `gnt1`.
5. A read is granted, then `rst` is asserted the next cycle: no `rvalid` appears and the outputs return to reset values.
6. With the macro, requests during `busy`: no grant until `busy` falls. The first read of any address returns 0.
